// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and request decode for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] Funct3Byte   = 3'b000;
    localparam logic [2:0] Funct3Half   = 3'b001;
    localparam logic [2:0] Funct3Word   = 3'b010;
    localparam logic [2:0] Funct3ByteU  = 3'b100;
    localparam logic [2:0] Funct3HalfU  = 3'b101;

    localparam logic [1:0] FaultNone     = 2'b00;
    localparam logic [1:0] FaultMisalign = 2'b01;
    localparam logic [1:0] FaultAccess   = 2'b10;
    localparam logic [1:0] FaultIllegal  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } lsu_state_e;

    // Illegal funct3 outranks misalignment.
    function automatic logic [1:0] decode_fault(input logic write, input logic [2:0] funct3,
                                                input logic [1:0] addr_lo);
        logic legal;
        logic misaligned;
        if (write) begin
            legal = (funct3 == Funct3Byte) || (funct3 == Funct3Half) || (funct3 == Funct3Word);
        end else begin
            legal = (funct3 == Funct3Byte) || (funct3 == Funct3Half) || (funct3 == Funct3Word) ||
                    (funct3 == Funct3ByteU) || (funct3 == Funct3HalfU);
        end
        case (funct3[1:0])
            2'b01:   misaligned = addr_lo[0];
            2'b10:   misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b0;
        endcase
        if (!legal) begin
            return FaultIllegal;
        end else if (misaligned) begin
            return FaultMisalign;
        end
        return FaultNone;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store replication and strobes, load lane select with extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_in,
    input  logic [31:0] load_word,
    output logic [31:0] store_data,
    output logic [3:0]  strobe,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        store_data = store_in;
        strobe     = 4'b0000;
        case (funct3[1:0])
            2'b00: begin
                store_data = {4{store_in[7:0]}};
                strobe     = 4'b0001 << offset;
            end
            2'b01: begin
                store_data = {2{store_in[15:0]}};
                strobe     = 4'b0011 << offset;
            end
            2'b10: begin
                store_data = store_in;
                strobe     = 4'b1111;
            end
            default: ;
        endcase
    end

    assign shifted = load_word >> {offset, 3'b000};

    always_comb begin
        load_data = 32'h0;
        case (funct3)
            Funct3Byte:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            Funct3Half:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            Funct3Word:  load_data = shifted;
            Funct3ByteU: load_data = {24'h0, shifted[7:0]};
            Funct3HalfU: load_data = {16'h0, shifted[15:0]};
            default:     load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: IDLE accepts and decodes, ACCESS touches memory
// for one cycle, RESP holds the result until the core takes it.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_fault,
    output logic [29:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_write_enable,
    input  logic [31:0] mem_rdata,
    input  logic        mem_read_capable,
    input  logic        mem_write_capable
);

    lsu_state_e  state_q, state_d;
    logic        write_q;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic [31:0] rdata_q;
    logic [1:0]  fault_q;
    logic [29:0] mem_address_q;
    logic [31:0] mem_wdata_q;

    logic        accept;
    logic [1:0]  req_fault;
    logic [2:0]  align_funct3;
    logic [1:0]  align_offset;
    logic [31:0] store_data;
    logic [3:0]  strobe;
    logic [31:0] load_data;

    assign accept    = req_valid && (state_q == StIdle);
    assign req_fault = decode_fault(req_write, req_funct3, req_addr[1:0]);

    // In IDLE the aligner sees the incoming request so store data can be latched on accept.
    assign align_funct3 = (state_q == StIdle) ? req_funct3    : funct3_q;
    assign align_offset = (state_q == StIdle) ? req_addr[1:0] : offset_q;

    lsu_align u_align (
        .funct3     (align_funct3),
        .offset     (align_offset),
        .store_in   (req_wdata),
        .load_word  (mem_rdata),
        .store_data (store_data),
        .strobe     (strobe),
        .load_data  (load_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (req_fault != FaultNone) ? StResp : StAccess;
                end
            end
            StAccess: state_d = StResp;
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            write_q       <= 1'b0;
            funct3_q      <= 3'b000;
            offset_q      <= 2'b00;
            rdata_q       <= 32'h0;
            fault_q       <= FaultNone;
            mem_address_q <= 30'h0;
            mem_wdata_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q  <= req_write;
                funct3_q <= req_funct3;
                offset_q <= req_addr[1:0];
                rdata_q  <= 32'h0;
                fault_q  <= req_fault;
                if (req_fault == FaultNone) begin
                    mem_address_q <= req_addr[31:2];
                    if (req_write) begin
                        mem_wdata_q <= store_data;
                    end
                end
            end
            if (state_q == StAccess) begin
                if (write_q) begin
                    fault_q <= mem_write_capable ? FaultNone : FaultAccess;
                    rdata_q <= 32'h0;
                end else begin
                    fault_q <= mem_read_capable ? FaultNone : FaultAccess;
                    rdata_q <= mem_read_capable ? load_data : 32'h0;
                end
            end
        end
    end

    assign req_ready        = (state_q == StIdle);
    assign resp_valid       = (state_q == StResp);
    assign resp_rdata       = rdata_q;
    assign resp_fault       = fault_q;
    assign mem_address      = mem_address_q;
    assign mem_wdata        = mem_wdata_q;
    assign mem_write_enable = (state_q == StAccess && write_q && mem_write_capable) ? strobe
                                                                                    : 4'b0000;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit: table of single transactions plus
// hand-written backpressure and mid-access reset sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_fault;
    logic [29:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_write_enable;
    logic [31:0] mem_rdata;
    logic        mem_read_capable;
    logic        mem_write_capable;

    int compared   = 0;
    int mismatched = 0;
    logic [29:0] prev_addr = 30'h0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_write         (req_write),
        .req_funct3        (req_funct3),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_rdata        (resp_rdata),
        .resp_fault        (resp_fault),
        .mem_address       (mem_address),
        .mem_wdata         (mem_wdata),
        .mem_write_enable  (mem_write_enable),
        .mem_rdata         (mem_rdata),
        .mem_read_capable  (mem_read_capable),
        .mem_write_capable (mem_write_capable)
    );

    typedef struct {
        logic        write;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrd;
        logic        rcap;
        logic        wcap;
        logic [1:0]  efault;
        logic [31:0] erdata;
        int          elat;
        logic [3:0]  ewe;
        logic [31:0] ewdata;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          lat;
        logic [29:0] exp_addr;
        @(negedge clk);
        chk($sformatf("v%0d req_ready_idle", idx), {31'h0, req_ready}, 32'd1);
        req_write         = v.write;
        req_funct3        = v.f3;
        req_addr          = v.addr;
        req_wdata         = v.wdata;
        mem_rdata         = v.mrd;
        mem_read_capable  = v.rcap;
        mem_write_capable = v.wcap;
        req_valid         = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        exp_addr = (v.elat == 2) ? v.addr[31:2] : prev_addr;
        chk($sformatf("v%0d mem_address", idx), {2'b00, mem_address}, {2'b00, exp_addr});
        chk($sformatf("v%0d we_first", idx), {28'h0, mem_write_enable},
            {28'h0, (v.elat == 2) ? v.ewe : 4'b0000});
        if (v.write && v.elat == 2) begin
            chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.ewdata);
        end
        while (!resp_valid && lat < 6) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk($sformatf("v%0d latency", idx), lat, v.elat);
        chk($sformatf("v%0d resp_valid", idx), {31'h0, resp_valid}, 32'd1);
        chk($sformatf("v%0d resp_rdata", idx), resp_rdata, v.erdata);
        chk($sformatf("v%0d resp_fault", idx), {30'h0, resp_fault}, {30'h0, v.efault});
        chk($sformatf("v%0d we_resp", idx), {28'h0, mem_write_enable}, 32'h0);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk($sformatf("v%0d resp_done", idx), {31'h0, resp_valid}, 32'd0);
        if (v.elat == 2) begin
            prev_addr = v.addr[31:2];
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [31:0] held;

        //            wr   f3      addr          wdata         mrd           rc wc flt  erdata     lat we      ewdata
        vecs[0]  = '{1'b1, 3'b000, 32'h80000003, 32'h000000A5, 32'h0,        1, 1, 2'd0, 32'h0,        2, 4'b1000, 32'hA5A5A5A5};
        vecs[1]  = '{1'b0, 3'b000, 32'h80000002, 32'h0,        32'h00F00000, 1, 1, 2'd0, 32'hFFFFFFF0, 2, 4'b0000, 32'h0};
        vecs[2]  = '{1'b0, 3'b100, 32'h80000002, 32'h0,        32'h00F00000, 1, 1, 2'd0, 32'h000000F0, 2, 4'b0000, 32'h0};
        vecs[3]  = '{1'b0, 3'b010, 32'h00000006, 32'h0,        32'h12345678, 1, 1, 2'd1, 32'h0,        1, 4'b0000, 32'h0};
        vecs[4]  = '{1'b1, 3'b010, 32'h00000100, 32'h12345678, 32'h0,        1, 0, 2'd2, 32'h0,        2, 4'b0000, 32'h12345678};
        vecs[5]  = '{1'b0, 3'b011, 32'h00000000, 32'h0,        32'hFFFFFFFF, 1, 1, 2'd3, 32'h0,        1, 4'b0000, 32'h0};
        vecs[6]  = '{1'b1, 3'b001, 32'h00000002, 32'h0000BEEF, 32'h0,        1, 1, 2'd0, 32'h0,        2, 4'b1100, 32'hBEEFBEEF};
        vecs[7]  = '{1'b0, 3'b001, 32'h00000002, 32'h0,        32'h80011234, 1, 1, 2'd0, 32'hFFFF8001, 2, 4'b0000, 32'h0};
        vecs[8]  = '{1'b0, 3'b101, 32'h00000002, 32'h0,        32'h80011234, 1, 1, 2'd0, 32'h00008001, 2, 4'b0000, 32'h0};
        vecs[9]  = '{1'b0, 3'b010, 32'h00000004, 32'h0,        32'hDEADBEEF, 1, 1, 2'd0, 32'hDEADBEEF, 2, 4'b0000, 32'h0};
        vecs[10] = '{1'b0, 3'b000, 32'h00000001, 32'h0,        32'h00007F00, 1, 1, 2'd0, 32'h0000007F, 2, 4'b0000, 32'h0};
        vecs[11] = '{1'b0, 3'b010, 32'h00000008, 32'h0,        32'hFFFFFFFF, 0, 1, 2'd2, 32'h0,        2, 4'b0000, 32'h0};
        vecs[12] = '{1'b1, 3'b001, 32'h00000003, 32'h00001111, 32'h0,        1, 1, 2'd1, 32'h0,        1, 4'b0000, 32'h0};
        vecs[13] = '{1'b1, 3'b101, 32'h00000001, 32'h00002222, 32'h0,        1, 1, 2'd3, 32'h0,        1, 4'b0000, 32'h0};
        vecs[14] = '{1'b0, 3'b110, 32'h00000003, 32'h0,        32'h0,        1, 1, 2'd3, 32'h0,        1, 4'b0000, 32'h0};
        vecs[15] = '{1'b1, 3'b010, 32'h00000010, 32'hCAFEF00D, 32'h0,        1, 1, 2'd0, 32'h0,        2, 4'b1111, 32'hCAFEF00D};
        vecs[16] = '{1'b0, 3'b100, 32'h00000003, 32'h0,        32'h80000000, 1, 1, 2'd0, 32'h00000080, 2, 4'b0000, 32'h0};

        reset = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_funct3 = 3'b000;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        resp_ready = 1'b0;
        mem_rdata = 32'h0;
        mem_read_capable = 1'b1;
        mem_write_capable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst req_ready", {31'h0, req_ready}, 32'd1);
        chk("rst resp_valid", {31'h0, resp_valid}, 32'd0);
        chk("rst resp_rdata", resp_rdata, 32'h0);
        chk("rst resp_fault", {30'h0, resp_fault}, 32'h0);
        chk("rst write_enable", {28'h0, mem_write_enable}, 32'h0);
        chk("rst mem_address", {2'b00, mem_address}, 32'h0);
        chk("rst mem_wdata", mem_wdata, 32'h0);

        for (int i = 0; i < 17; i++) begin
            run_vec(vecs[i], i);
        end

        // Response backpressure: result must hold while resp_ready stays low.
        @(negedge clk);
        req_write = 1'b0;
        req_funct3 = 3'b010;
        req_addr = 32'h00000020;
        mem_rdata = 32'h11223344;
        mem_read_capable = 1'b1;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 6) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("bp latency", lat, 2);
        held = 32'h11223344;
        for (int c = 0; c < 5; c++) begin
            mem_rdata = $urandom;
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d resp_valid", c), {31'h0, resp_valid}, 32'd1);
            chk($sformatf("bp%0d resp_rdata", c), resp_rdata, held);
            chk($sformatf("bp%0d req_ready", c), {31'h0, req_ready}, 32'd0);
        end
        // A request waiting during the handshake cycle must not be taken that cycle.
        @(negedge clk);
        resp_ready = 1'b1;
        req_write = 1'b1;
        req_funct3 = 3'b000;
        req_addr = 32'h00000040;
        req_wdata = 32'h0000005A;
        req_valid = 1'b1;
        chk("hs req_ready_before", {31'h0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        req_valid = 1'b0;
        chk("hs req_ready_after", {31'h0, req_ready}, 32'd1);
        chk("hs resp_valid_after", {31'h0, resp_valid}, 32'd0);
        chk("hs write_enable", {28'h0, mem_write_enable}, 32'h0);
        @(posedge clk);
        #1;
        chk("hs idle_hold", {31'h0, req_ready}, 32'd1);

        // Reset during ACCESS of a store aborts it.
        @(negedge clk);
        req_write = 1'b1;
        req_funct3 = 3'b010;
        req_addr = 32'h00000040;
        req_wdata = 32'h55AA55AA;
        mem_write_capable = 1'b1;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("ra we_access", {28'h0, mem_write_enable}, 32'hF);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("ra we_after", {28'h0, mem_write_enable}, 32'h0);
        chk("ra resp_valid", {31'h0, resp_valid}, 32'd0);
        chk("ra mem_address", {2'b00, mem_address}, 32'h0);
        chk("ra mem_wdata", mem_wdata, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("ra%0d req_ready", c), {31'h0, req_ready}, 32'd1);
            chk($sformatf("ra%0d resp_valid", c), {31'h0, resp_valid}, 32'd0);
            chk($sformatf("ra%0d we", c), {28'h0, mem_write_enable}, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have no parameters; all widths SHALL be fixed as listed.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  reset SHALL be synchronous and active-high.
REQ-004 req_valid  input  1  core presents an access request.
REQ-005 req_ready  output  1  unit accepts a request; a transfer occurs when req_valid and req_ready are both high.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I width/sign code.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 resp_valid  output  1  response available.
REQ-011 resp_ready  input  1  core consumes the response.
REQ-012 resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and faults.
REQ-013 resp_fault  output  2  fault code: 00 none, 01 misaligned, 10 access fault, 11 illegal funct3.
REQ-014 mem_address  output  30  word address, bits [31:2], to the memory decoder.
REQ-015 mem_wdata  output  32  lane-aligned store data to the memory decoder.
REQ-016 mem_write_enable  output  4  per-byte write strobes.
REQ-017 mem_rdata  input  32  combinational read word from the decoder.
REQ-018 mem_read_capable  input  1  decoded region is readable.
REQ-019 mem_write_capable  input  1  decoded region is writable.

Function
REQ-020 The FSM SHALL have three states, IDLE, ACCESS and RESP, and req_ready SHALL be 1 only in IDLE.
REQ-021 On acceptance the unit SHALL latch write, funct3, addr and wdata and SHALL decode them in the same cycle.
REQ-022 Legal load funct3 codes SHALL be 000 LB, 001 LH, 010 LW, 100 LBU and 101 LHU; legal store codes SHALL be 000 SB, 001 SH and 010 SW; any other code SHALL yield fault 11.
REQ-023 Misalignment SHALL be defined as: halfword access with addr[0] = 1, or word access with addr[1:0] != 00; a misaligned access SHALL yield fault 01.
REQ-024 If both the illegal-funct3 and misaligned conditions apply, fault 11 SHALL take priority.
REQ-025 A faulting decode SHALL go IDLE -> RESP with no memory access; response latency SHALL be 1 cycle.
REQ-026 A legal decode SHALL go IDLE -> ACCESS, then ACCESS -> RESP after exactly one cycle; response latency SHALL be 2 cycles.
REQ-027 In ACCESS, mem_address SHALL equal addr[31:2]; mem_address SHALL hold its last value in all other states.
REQ-028 Store in ACCESS with mem_write_capable = 1: mem_write_enable SHALL be SB 0001<<addr[1:0], SH 0011<<addr[1:0], SW 1111.
REQ-029 Store in ACCESS with mem_write_capable = 0: mem_write_enable SHALL be 0000 and the response SHALL carry fault 10.
REQ-030 mem_write_enable SHALL be 0000 in every state except ACCESS and SHALL never be asserted for more than one cycle per request.
REQ-031 mem_wdata SHALL be: SB = the byte replicated to 4 lanes; SH = the halfword replicated to 2 lanes; SW = the word unchanged.
REQ-032 Load in ACCESS: if mem_read_capable = 1, the unit SHALL capture mem_rdata at the end of the ACCESS cycle, select the lane addressed by addr[1:0], and sign-extend (LB/LH) or zero-extend (LBU/LHU); otherwise it SHALL return fault 10 with rdata 0.
REQ-033 In RESP, resp_valid SHALL be 1, and resp_rdata/resp_fault SHALL be held stable until resp_valid and resp_ready are both high; the FSM SHALL then return to IDLE the next cycle.
REQ-034 A new request SHALL never be accepted in the same cycle a response completes.

Reset
REQ-035 reset SHALL force state IDLE and set resp_valid 0, resp_rdata 0, resp_fault 00, mem_write_enable 0000, mem_address 0 and mem_wdata 0.
REQ-036 Reset asserted in ACCESS or RESP SHALL abort the request with no response and no further write strobe after the reset edge.
REQ-037 reset SHALL take priority over every other input.

Structure
REQ-038 Package lsu_pkg SHALL hold the funct3 constants, the fault-code constants and the state enumeration.
REQ-039 One combinational sub-module, lsu_align, SHALL provide store lane replication, strobe generation, and load lane select with extension.

Verification
REQ-040 SB at 0x80000003, data 0x000000A5 -> one-cycle mem_write_enable 1000, mem_wdata 0xA5A5A5A5, mem_address 0x20000000, fault 00.
REQ-041 LB at 0x80000002, mem_rdata 0x00F00000 -> resp_rdata 0xFFFFFFF0; LBU at the same address -> 0x000000F0; both at 2-cycle latency.
REQ-042 LW at 0x00000006 -> fault 01 one cycle after acceptance; write strobes and mem_address unchanged.
REQ-043 SW at 0x00000100 with mem_write_capable = 0 -> strobes stay 0000, fault 10; funct3 011 -> fault 11.
REQ-044 Response with resp_ready held low for 5 cycles -> resp_valid and resp_rdata stable throughout, req_ready 0 until 1 cycle after the handshake.
REQ-045 reset asserted in ACCESS of an SW -> no resp_valid, write_enable 0000 from the next cycle, req_ready 1 after reset releases.
